// File: rtl/fir_audio_pkg.sv
// Shared FIR audio types and output formatting.
// Rounds, scales and clamps accumulator results to PCM.
package fir_audio_pkg;

  localparam int ACC_W = 39;
  localparam int OUT_W = 16;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [OUT_W-1:0] pcm_t;

  typedef struct packed {
    logic sat;
    pcm_t pcm;
  } fmt_t;

  localparam logic [ACC_W:0] RND_ONE = {{ACC_W{1'b0}}, 1'b1};

  // Round half up, arithmetic shift, clamp to PCM range.
  function automatic fmt_t sat_round(
    input acc_t        acc,
    input int unsigned shift
  );
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] shd;
    logic signed [ACC_W:0] pmax;
    logic signed [ACC_W:0] pmin;
    fmt_t                  r;
    pmax = (ACC_W+1)'(2**(OUT_W-1) - 1);
    pmin = ~pmax;
    rnd  = (shift == 0) ? '0 : RND_ONE << (shift - 1);
    ext  = {acc[ACC_W-1], acc} + rnd;
    shd  = ext >>> shift;
    r.sat = 1'b0;
    r.pcm = shd[OUT_W-1:0];
    if (shd > pmax) begin
      r.sat = 1'b1;
      r.pcm = pmax[OUT_W-1:0];
    end else if (shd < pmin) begin
      r.sat = 1'b1;
      r.pcm = pmin[OUT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/i2s_tx_serializer.sv
// I2S master transmitter: SCK divider, framing,
// WS/SD generation and per-frame word capture.
module i2s_tx_serializer
  import fir_audio_pkg::*;
#(
  parameter int SCK_HALF = 4,
  parameter bit MONO_DUP = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  pcm_t i_pcm,
  input  logic i_fresh,
  output logic o_cap,
  output logic o_underrun,
  output logic o_sck,
  output logic o_ws,
  output logic o_sd
);

  localparam int FRAME = 2 * OUT_W;
  localparam int BW    = $clog2(FRAME);
  localparam int IW    = $clog2(OUT_W);
  localparam int DW    = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

  localparam logic [DW-1:0] DIV_END = DW'(SCK_HALF - 1);
  localparam logic [BW-1:0] BIT_END = BW'(FRAME - 1);
  localparam logic [BW-1:0] SLOT_W  = BW'(OUT_W);

  logic [DW-1:0] r_div;
  logic          r_sck;
  logic [BW-1:0] r_bit;
  logic          r_ws;
  logic          r_sd;
  logic          r_und;
  pcm_t          r_frame_l;
  pcm_t          r_frame_r;

  logic          w_tick;
  logic          w_fall;
  logic          w_cap;
  logic [BW-1:0] w_bit_nxt;
  logic          w_ws_nxt;
  logic          w_first;
  logic          w_left;
  logic [IW-1:0] w_idx;
  logic          w_sd_nxt;

  assign w_tick = (r_div == DIV_END);
  assign w_fall = w_tick & r_sck;
  assign w_cap  = w_fall & w_first;

  // Next bit position and the data bit it drives.
  always_comb begin
    w_bit_nxt = (r_bit == BIT_END) ? '0 : r_bit + 1'b1;
    w_ws_nxt  = (w_bit_nxt >= SLOT_W);
    w_first   = (w_bit_nxt == '0);
    w_left    = !w_first && (w_bit_nxt <= SLOT_W);
    w_idx     = '0;
    w_sd_nxt  = 1'b0;
    unique case (1'b1)
      w_first: begin
        w_sd_nxt = r_frame_r[0];
      end
      w_left: begin
        w_idx    = IW'(OUT_W - 32'(w_bit_nxt));
        w_sd_nxt = r_frame_l[w_idx];
      end
      default: begin
        w_idx    = IW'(FRAME - 32'(w_bit_nxt));
        w_sd_nxt = r_frame_r[w_idx];
      end
    endcase
  end

  // Divider, framing, fall-aligned WS/SD and capture.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_div     <= '0;
      r_sck     <= 1'b0;
      r_bit     <= '0;
      r_ws      <= 1'b0;
      r_sd      <= 1'b0;
      r_und     <= 1'b0;
      r_frame_l <= '0;
      r_frame_r <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) begin
        r_sck <= ~r_sck;
      end
      if (w_fall) begin
        r_bit <= w_bit_nxt;
        r_ws  <= w_ws_nxt;
        r_sd  <= w_sd_nxt;
      end
      if (w_cap) begin
        r_frame_l <= i_pcm;
        r_frame_r <= MONO_DUP ? i_pcm : '0;
      end
      r_und <= w_cap & ~i_fresh;
    end
  end

  assign o_cap      = w_cap;
  assign o_underrun = r_und;
  assign o_sck      = r_sck;
  assign o_ws       = r_ws;
  assign o_sd       = r_sd;

endmodule

// File: rtl/fir_i2s_output.sv
// FIR output stage: format accumulator to PCM,
// buffer one word and stream it as I2S master.
module fir_i2s_output
  import fir_audio_pkg::*;
#(
  parameter int ACC_W    = 39,
  parameter int OUT_W    = 16,
  parameter int SHIFT    = 15,
  parameter int SCK_HALF = 4,
  parameter bit MONO_DUP = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic signed [ACC_W-1:0] i_result,
  input  logic                    i_valid,
  input  logic                    i_sat_clr,
  output logic                    o_sck,
  output logic                    o_ws,
  output logic                    o_sd,
  output logic                    o_sat,
  output logic                    o_underrun,
  output logic                    o_overrun
);

  logic signed [OUT_W-1:0] r_pending;
  logic                    r_fresh;
  logic                    r_sat;
  logic                    r_ovr;

  fmt_t w_fmt;
  logic w_cap;

  assign w_fmt = sat_round(i_result, SHIFT);

  // Pending word and its fresh flag; new data beats capture.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_pending <= '0;
      r_fresh   <= 1'b0;
    end else if (i_valid) begin
      r_pending <= w_fmt.pcm;
      r_fresh   <= 1'b1;
    end else if (w_cap) begin
      r_fresh   <= 1'b0;
    end
  end

  // Overrun when an unused fresh word is overwritten.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ovr <= 1'b0;
    end else begin
      r_ovr <= i_valid & r_fresh & ~w_cap;
    end
  end

  // Sticky saturation; a new saturation beats the clear.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sat <= 1'b0;
    end else if (i_valid && w_fmt.sat) begin
      r_sat <= 1'b1;
    end else if (i_sat_clr) begin
      r_sat <= 1'b0;
    end
  end

  i2s_tx_serializer #(
    .SCK_HALF (SCK_HALF),
    .MONO_DUP (MONO_DUP)
  ) u_ser (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_pcm      (r_pending),
    .i_fresh    (r_fresh),
    .o_cap      (w_cap),
    .o_underrun (o_underrun),
    .o_sck      (o_sck),
    .o_ws       (o_ws),
    .o_sd       (o_sd)
  );

  assign o_sat     = r_sat;
  assign o_overrun = r_ovr;

endmodule

// File: tb/tb_fir_i2s_output.sv
// Self-checking bench for fir_i2s_output.
// Decodes the I2S stream and compares with a frame model.
module tb_fir_i2s_output;

  localparam int FRAME = 2 * 16 * 2 * 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [38:0] i_result = '0;
  logic               i_valid = 1'b0;
  logic               i_sat_clr = 1'b0;
  logic               o_sck;
  logic               o_ws;
  logic               o_sd;
  logic               o_sat;
  logic               o_underrun;
  logic               o_overrun;

  int vectors = 0;
  int miscompares = 0;
  int cyc;

  always #5 clk = ~clk;

  fir_i2s_output dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_result   (i_result),
    .i_valid    (i_valid),
    .i_sat_clr  (i_sat_clr),
    .o_sck      (o_sck),
    .o_ws       (o_ws),
    .o_sd       (o_sd),
    .o_sat      (o_sat),
    .o_underrun (o_underrun),
    .o_overrun  (o_overrun)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // I2S receiver: sample on SCK rise, slot starts after a WS change.
  logic [15:0] left_q[$];
  logic [15:0] right_q[$];
  logic        m_sck;
  logic        m_ws;
  logic        m_act;
  logic        m_slot;
  int          m_cnt;
  logic [15:0] m_sh;
  int          und_cnt;
  int          ovr_cnt;

  initial begin : mon
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_sck = 1'b0; m_ws = 1'b1; m_act = 1'b0; m_slot = 1'b0;
        m_cnt = 0; m_sh = '0; und_cnt = 0; ovr_cnt = 0;
        left_q.delete(); right_q.delete();
      end else begin
        if (o_underrun) und_cnt++;
        if (o_overrun) ovr_cnt++;
        if (o_sck && !m_sck) begin
          if (m_act) begin
            m_sh = {m_sh[14:0], o_sd};
            m_cnt++;
            if (m_cnt == 16) begin
              if (m_slot) right_q.push_back(m_sh);
              else        left_q.push_back(m_sh);
              m_act = 1'b0;
            end
          end
          if (o_ws != m_ws) begin
            m_act = 1'b1; m_cnt = 0; m_slot = o_ws;
          end
          m_ws = o_ws;
        end
        m_sck = o_sck;
      end
    end
  end

  // Reference model: log of accepted samples (cycle, word, sat).
  int ev_c[$];
  int ev_v[$];
  bit ev_s[$];

  function automatic int ref_fmt(input longint x, output bit sat);
    longint y;
    y = (x + 64'sd16384) >>> 15;
    sat = 1'b0;
    if (y > 32767) begin sat = 1'b1; y = 32767; end
    else if (y < -32768) begin sat = 1'b1; y = -32768; end
    return int'(y);
  endfunction

  function automatic int exp_word(input int m);
    int v = 0;
    foreach (ev_c[i]) if (ev_c[i] < FRAME * m) v = ev_v[i];
    return v;
  endfunction

  function automatic int exp_und(input int caps);
    int n = 0;
    for (int m = 1; m <= caps; m++) begin
      bit hit = 1'b0;
      foreach (ev_c[i])
        if (ev_c[i] >= FRAME*(m-1) && ev_c[i] < FRAME*m) hit = 1'b1;
      if (!hit) n++;
    end
    return n;
  endfunction

  function automatic int exp_ovr();
    int n = 0;
    foreach (ev_c[i]) begin
      int lo;
      bit hit;
      lo = (ev_c[i] / FRAME) * FRAME;
      hit = 1'b0;
      if (ev_c[i] % FRAME != 0)
        for (int j = 0; j < i; j++)
          if (ev_c[j] >= lo && ev_c[j] < ev_c[i]) hit = 1'b1;
      if (hit) n++;
    end
    return n;
  endfunction

  function automatic bit exp_sat();
    bit s = 1'b0;
    foreach (ev_s[i]) s |= ev_s[i];
    return s;
  endfunction

  task automatic wait_cyc(input int n);
    int b = 0;
    while (cyc < n && b < 100000) begin
      @(posedge clk); #1; b++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ev_c.delete(); ev_v.delete(); ev_s.delete();
  endtask

  task automatic pulse(input int n, input longint x,
                       input bit v, input bit clr);
    bit s;
    int w;
    if (v) begin
      w = ref_fmt(x, s);
      ev_c.push_back(n); ev_v.push_back(w); ev_s.push_back(s);
    end
    wait_cyc(n - 1);
    i_result = 39'(x); i_valid = v; i_sat_clr = clr;
    @(posedge clk); #1;
    i_valid = 1'b0; i_sat_clr = 1'b0;
  endtask

  task automatic check_frame(input int m, input int exp, input string nm);
    int b = 0;
    while (right_q.size() <= m && b < 3000) begin
      @(posedge clk); #1; b++;
    end
    vectors++;
    if (right_q.size() <= m) begin
      miscompares++;
      $display("FAIL %s: frame %0d not received, got %0d words required %0d",
               nm, m, right_q.size(), m + 1);
    end else begin
      if (left_q[m] !== 16'(exp)) begin
        miscompares++;
        $display("FAIL %s: left frame %0d got %h required %h",
                 nm, m, left_q[m], 16'(exp));
      end
      vectors++;
      if (right_q[m] !== 16'(exp)) begin
        miscompares++;
        $display("FAIL %s: right frame %0d got %h required %h",
                 nm, m, right_q[m], 16'(exp));
      end
    end
  endtask

  task automatic check_bit(input logic got, input logic exp, input string nm);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b required %b", nm, got, exp);
    end
  endtask

  task automatic check_int(input int got, input int exp, input string nm);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", nm, got, exp);
    end
  endtask

  task automatic test_reset();
    #20;
    check_int(int'({o_sck, o_ws, o_sd, o_sat, o_underrun, o_overrun}),
              0, "reset_outputs");
    do_reset();
    wait_cyc(2);
    check_int(int'({o_sck, o_ws, o_sd, o_sat, o_underrun, o_overrun}),
              0, "post_reset_outputs");
  endtask

  task automatic test_rounding();
    longint xs[4] = '{16383, 16384, -16384, -16385};
    int     ws[4] = '{0, 1, 0, -1};
    do_reset();
    for (int i = 0; i < 4; i++) pulse(FRAME*i + 100, xs[i], 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) check_frame(i + 1, ws[i], "rounding");
    check_bit(o_sat, 1'b0, "rounding_no_sat");
  endtask

  task automatic test_saturation();
    do_reset();
    pulse(100, 64'sd1 <<< 30, 1'b1, 1'b0);
    wait_cyc(101);
    check_bit(o_sat, 1'b1, "sat_set");
    pulse(356, -(64'sd1 <<< 31), 1'b1, 1'b0);
    check_frame(1, 32767, "sat_pos");
    check_frame(2, -32768, "sat_neg");
    pulse(800, 0, 1'b0, 1'b1);
    wait_cyc(801);
    check_bit(o_sat, 1'b0, "sat_clear");
    pulse(900, 64'sd1 <<< 34, 1'b1, 1'b1);
    wait_cyc(901);
    check_bit(o_sat, 1'b1, "sat_beats_clear");
  endtask

  task automatic test_serial_format();
    int  rises = 0;
    int  bad_per = 0;
    int  lo_ok = 0;
    int  hi_ok = 0;
    int  last = 0;
    logic prev;
    do_reset();
    pulse(100, longint'(-23101) * 32768, 1'b1, 1'b0);
    wait_cyc(FRAME);
    prev = o_sck;
    for (int c = FRAME + 1; c <= 2 * FRAME; c++) begin
      wait_cyc(c);
      if (o_sck && !prev) begin
        if (rises > 0 && c - last != 8) bad_per++;
        if (rises < 16 && o_ws == 1'b0) lo_ok++;
        if (rises >= 16 && o_ws == 1'b1) hi_ok++;
        last = c;
        rises++;
      end
      prev = o_sck;
    end
    check_int(rises, 32, "sck_rises_per_frame");
    check_int(bad_per, 0, "sck_period_8");
    check_int(lo_ok, 16, "ws_low_16");
    check_int(hi_ok, 16, "ws_high_16");
    check_frame(1, 16'hA5C3, "serial_a5c3");
  endtask

  task automatic test_underrun();
    int v;
    v = int'($urandom_range(0, 60000)) - 30000;
    do_reset();
    pulse(100, longint'(v) * 32768, 1'b1, 1'b0);
    check_frame(1, v, "und_frame1");
    wait_cyc(2 * FRAME + 100);
    check_int(und_cnt, exp_und(2), "und_after_cap2");
    check_frame(2, v, "und_repeat2");
    wait_cyc(3 * FRAME + 100);
    check_int(und_cnt, exp_und(3), "und_after_cap3");
    check_frame(3, v, "und_repeat3");
  endtask

  task automatic test_overrun_collision();
    do_reset();
    pulse(50, 64'sd100 * 32768, 1'b1, 1'b0);
    pulse(150, 64'sd200 * 32768, 1'b1, 1'b0);
    wait_cyc(200);
    check_int(ovr_cnt, 1, "ovr_once");
    pulse(300, 64'sd300 * 32768, 1'b1, 1'b0);
    pulse(2 * FRAME, 64'sd400 * 32768, 1'b1, 1'b0);
    wait_cyc(600);
    check_int(ovr_cnt, exp_ovr(), "ovr_collision");
    check_frame(1, 200, "ovr_newest");
    check_frame(2, 300, "coll_old");
    check_frame(3, 400, "coll_new");
    wait_cyc(4 * FRAME + 100);
    check_int(und_cnt, exp_und(4), "coll_und");
  endtask

  task automatic test_async_reset();
    do_reset();
    pulse(100, 64'sd1 <<< 35, 1'b1, 1'b0);
    wait_cyc(400);
    #2;
    rst_n = 1'b0;
    #1;
    check_int(int'({o_sck, o_ws, o_sd, o_sat, o_underrun, o_overrun}),
              0, "async_reset_outputs");
    do_reset();
    wait_cyc(3);
    check_bit(o_sck, 1'b0, "sck_low_cyc3");
    wait_cyc(4);
    check_bit(o_sck, 1'b1, "sck_rise_cyc4");
    check_frame(0, 0, "first_frame_zero");
    wait_cyc(FRAME + 100);
    check_int(und_cnt, 1, "first_capture_underrun");
    check_frame(1, 0, "second_frame_zero");
  endtask

  task automatic test_random();
    int     M = 10;
    int     cs[$];
    longint xs[$];
    longint raw;
    int     base;
    int     k;
    do_reset();
    for (int m = 1; m <= M; m++) begin
      base = FRAME * (m - 1);
      k = int'($urandom_range(0, 2));
      if (k >= 1) cs.push_back(base + int'($urandom_range(4, 120)));
      if (k == 2) cs.push_back(base + int'($urandom_range(121, 250)));
      if ($urandom_range(0, 3) == 0) cs.push_back(FRAME * m);
    end
    foreach (cs[i]) begin
      raw = longint'({$urandom, $urandom});
      raw = (raw <<< 25) >>> (25 + int'($urandom_range(4, 26)));
      xs.push_back(raw);
    end
    foreach (cs[i]) pulse(cs[i], xs[i], 1'b1, 1'b0);
    for (int m = 1; m <= M; m++) check_frame(m, exp_word(m), "random_frame");
    wait_cyc(FRAME * (M + 1) + 100);
    check_int(und_cnt, exp_und(M + 1), "random_underruns");
    check_int(ovr_cnt, exp_ovr(), "random_overruns");
    check_bit(o_sat, exp_sat(), "random_sat");
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_serial_format();
    test_underrun();
    test_overrun_collision();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
